rf_wb_ctrl: RTL and testbench

Write-back controller for the 32x32 register file's single write port. It shares that port between the single-cycle ALU write-back and a long-latency unit (load/div), which writes through a small skid FIFO. It also keeps a busy scoreboard of registers with pending long-latency writes and stalls decode on RAW/WAW hazards against them. It sits between execute/write-back and the register file write port (wr_en, rd_addr_i, rd_data_i).

---
 rtl/rf_wb_pkg.sv | 16 +
 rtl/rf_wb_fifo.sv | 51 +++++
 rtl/rf_wb_ctrl.sv | 138 +++++++++++++
 tb/tb_rf_wb_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared widths and the long-latency write-back entry for the register file write controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    // One pending long-latency result: destination register and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Skid FIFO holding long-latency results until the register file write port is free.
// Latency: a push is visible at the head one cycle later; head output is read combinationally.
// Backpressure: o_full blocks pushes; pushes while full and pops while empty are ignored.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  wb_entry_t i_push_dat,
    input  logic      i_pop,
    output wb_entry_t o_head_dat,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    wb_entry_t   r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

    // Advance read/write pointers; reset empties the FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset; entries are only observed between valid pointers.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_rst) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-port controller: ALU pass-through, long-latency skid FIFO, busy scoreboard, decode stall.
// Latency: ALU write is combinational; a long result pushed in cycle N can be written in N+1 at the earliest.
// Backpressure: ALU always wins the port; long unit sees long_ready_o=!full; decode sees stall_o on hazard/cap/starve.
module rf_wb_ctrl
    import rf_wb_pkg::*;
#(
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid_i,
    input  logic                  issue_long_i,
    input  logic [REG_ADDR_W-1:0] issue_rs1_i,
    input  logic [REG_ADDR_W-1:0] issue_rs2_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    output logic                  stall_o,
    input  logic                  alu_wr_en_i,
    input  logic [REG_ADDR_W-1:0] alu_rd_addr_i,
    input  logic [XLEN-1:0]       alu_rd_data_i,
    input  logic                  long_valid_i,
    output logic                  long_ready_o,
    input  logic [REG_ADDR_W-1:0] long_rd_addr_i,
    input  logic [XLEN-1:0]       long_rd_data_i,
    output logic                  wr_en_o,
    output logic [REG_ADDR_W-1:0] wr_addr_o,
    output logic [XLEN-1:0]       wr_data_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);
    localparam logic [STV_W-1:0] STV_ONE = STV_W'(1);

    // Bit 0 exists only to make indexing by register number direct; it is never set.
    logic [NUM_REGS-1:0] r_busy;
    logic [CNT_W-1:0]    r_outstanding;
    logic [STV_W-1:0]    r_starve;

    wb_entry_t           w_head;
    wb_entry_t           w_push_dat;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_hazard;
    logic                w_cap;
    logic                w_starve;
    logic                w_stall;
    logic                w_set;
    logic                w_clr;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    assign w_push_dat.addr = long_rd_addr_i;
    assign w_push_dat.data = long_rd_data_i;
    assign w_push          = long_valid_i && !w_full && !rst;
    assign long_ready_o    = !w_full;

    rf_wb_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Write-port arbitration: ALU first, then FIFO head (popped when it gets the port).
    always_comb begin
        wr_en_o   = 1'b0;
        wr_addr_o = '0;
        wr_data_o = '0;
        w_pop     = 1'b0;
        if (!rst) begin
            if (alu_wr_en_i) begin
                wr_en_o   = 1'b1;
                wr_addr_o = alu_rd_addr_i;
                wr_data_o = alu_rd_data_i;
            end else if (!w_empty) begin
                w_pop     = 1'b1;
                wr_en_o   = (w_head.addr != '0);
                wr_addr_o = w_head.addr;
                wr_data_o = w_head.data;
            end
        end
    end

    // Decode stall and scoreboard set/clear requests; hazards use registered busy bits only.
    always_comb begin
        w_hazard   = r_busy[issue_rs1_i] | r_busy[issue_rs2_i] | r_busy[issue_rd_i];
        w_cap      = issue_long_i && (r_outstanding == CNT_MAX);
        w_starve   = (r_starve >= STV_MAX);
        w_stall    = !rst && (w_hazard || w_cap || w_starve);
        w_set      = issue_valid_i && issue_long_i && !w_stall && (issue_rd_i != '0);
        w_clr      = w_pop && r_busy[w_head.addr];
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_set) w_set_mask[issue_rd_i]  = 1'b1;
        if (w_clr) w_clr_mask[w_head.addr] = 1'b1;
    end

    assign stall_o = w_stall;

    // Busy bits and outstanding count; a same-cycle set and clear leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= '0;
            r_outstanding <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
            if (w_set && !w_clr) begin
                r_outstanding <= r_outstanding + CNT_ONE;
            end else if (!w_set && w_clr) begin
                r_outstanding <= r_outstanding - CNT_ONE;
            end
        end
    end

    // Count consecutive cycles the FIFO head is locked out by the ALU, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!w_empty && alu_wr_en_i) begin
            if (r_starve != STV_MAX) r_starve <= r_starve + STV_ONE;
        end else begin
            r_starve <= '0;
        end
    end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: directed scenarios plus random traffic against a queue-based model.
// Latency: expected writes are queued at stimulus time and popped by an independent write-port monitor.
// Backpressure: long results are held on the bench side until the model predicts acceptance.
module tb_rf_wb_ctrl;
    import rf_wb_pkg::*;

    localparam int DEPTH = 2;
    localparam int MAXO  = 4;
    localparam int SLIM  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid_i, issue_long_i;
    logic [4:0]  issue_rs1_i, issue_rs2_i, issue_rd_i;
    logic        stall_o;
    logic        alu_wr_en_i;
    logic [4:0]  alu_rd_addr_i;
    logic [31:0] alu_rd_data_i;
    logic        long_valid_i, long_ready_o;
    logic [4:0]  long_rd_addr_i;
    logic [31:0] long_rd_data_i;
    logic        wr_en_o;
    logic [4:0]  wr_addr_o;
    logic [31:0] wr_data_o;

    always #5 clk = ~clk;

    rf_wb_ctrl #(
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .STARVE_LIMIT    (SLIM)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid_i  (issue_valid_i),
        .issue_long_i   (issue_long_i),
        .issue_rs1_i    (issue_rs1_i),
        .issue_rs2_i    (issue_rs2_i),
        .issue_rd_i     (issue_rd_i),
        .stall_o        (stall_o),
        .alu_wr_en_i    (alu_wr_en_i),
        .alu_rd_addr_i  (alu_rd_addr_i),
        .alu_rd_data_i  (alu_rd_data_i),
        .long_valid_i   (long_valid_i),
        .long_ready_o   (long_ready_o),
        .long_rd_addr_i (long_rd_addr_i),
        .long_rd_data_i (long_rd_data_i),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: pending results in arrival order, reserved registers, blocked-head age.
    wb_entry_t   m_fifo[$];
    bit          m_busy[32];
    int          m_out = 0;
    int          m_starve = 0;
    bit          m_pushed;
    wb_entry_t   exp_q[$];
    logic [4:0]  pend_q[$];
    logic [31:0] rf_obs[32];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_stall();
        bit hz;
        hz = (issue_rs1_i != 0 && m_busy[issue_rs1_i]) ||
             (issue_rs2_i != 0 && m_busy[issue_rs2_i]) ||
             (issue_rd_i  != 0 && m_busy[issue_rd_i]);
        return hz || (m_starve >= SLIM) || (issue_long_i && m_out == MAXO);
    endfunction

    // One clock: predict, queue expected write, check outputs at negedge, advance model at posedge.
    task automatic step();
        bit nonempty, exp_rdy, exp_stall, pop, push, acc;
        wb_entry_t e;
        nonempty  = m_fifo.size() > 0;
        exp_rdy   = m_fifo.size() < DEPTH;
        exp_stall = !rst && model_stall();
        pop       = !rst && !alu_wr_en_i && nonempty;
        push      = !rst && long_valid_i && exp_rdy;
        acc       = !rst && issue_valid_i && issue_long_i && !exp_stall && issue_rd_i != 0;
        m_pushed  = push;
        if (!rst && alu_wr_en_i) begin
            assert (!m_busy[alu_rd_addr_i]) else $error("ALU write to busy register x%0d", alu_rd_addr_i);
            e.addr = alu_rd_addr_i;
            e.data = alu_rd_data_i;
            exp_q.push_back(e);
        end else if (pop && m_fifo[0].addr != 0) begin
            exp_q.push_back(m_fifo[0]);
        end
        @(negedge clk);
        check("stall_o", {31'b0, stall_o}, {31'b0, exp_stall});
        check("long_ready_o", {31'b0, long_ready_o}, {31'b0, exp_rdy});
        @(posedge clk);
        if (rst) begin
            m_fifo.delete();
            m_busy   = '{default: 1'b0};
            m_out    = 0;
            m_starve = 0;
        end else begin
            if (nonempty && alu_wr_en_i) m_starve = (m_starve < SLIM) ? m_starve + 1 : SLIM;
            else                         m_starve = 0;
            if (pop) begin
                e = m_fifo.pop_front();
                if (m_busy[e.addr]) begin
                    m_busy[e.addr] = 1'b0;
                    m_out--;
                end
            end
            if (push) begin
                e.addr = long_rd_addr_i;
                e.data = long_rd_data_i;
                m_fifo.push_back(e);
            end
            if (acc) begin
                m_busy[issue_rd_i] = 1'b1;
                m_out++;
                pend_q.push_back(issue_rd_i);
            end
        end
        #1;
    endtask

    // Write-port monitor: every cycle either consumes the queued expectation or must stay quiet.
    initial begin
        wb_entry_t e;
        forever begin
            @(negedge clk);
            if (wr_en_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL wr_unexpected: got write x%0d=%h, required no write (t=%0t)", wr_addr_o, wr_data_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr_o", {27'b0, wr_addr_o}, {27'b0, e.addr});
                    check("wr_data_o", wr_data_o, e.data);
                    rf_obs[wr_addr_o] = wr_data_o;
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL wr_missing: got wr_en_o=%b, required write x%0d=%h (t=%0t)", wr_en_o, e.addr, e.data, $time);
            end
        end
    end

    task automatic idle();
        issue_valid_i = 0; issue_long_i = 0;
        issue_rs1_i = 0; issue_rs2_i = 0; issue_rd_i = 0;
        alu_wr_en_i = 0; alu_rd_addr_i = 0; alu_rd_data_i = 0;
        long_valid_i = 0; long_rd_addr_i = 0; long_rd_data_i = 0;
    endtask

    task automatic alu_rand(bit en);
        logic [4:0] a;
        do a = 5'($urandom_range(0, 31)); while (m_busy[a]);
        alu_wr_en_i   = en;
        alu_rd_addr_i = a;
        alu_rd_data_i = $urandom;
    endtask

    task automatic issue(bit v, bit lng, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
        issue_valid_i = v; issue_long_i = lng;
        issue_rs1_i = rs1; issue_rs2_i = rs2; issue_rd_i = rd;
    endtask

    task automatic long_drive(bit v, logic [4:0] rd, logic [31:0] d);
        long_valid_i = v; long_rd_addr_i = rd; long_rd_data_i = d;
    endtask

    initial begin
        bit done;
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        step();
        rst = 1'b0;

        // Read-after-long-write hazard on x5.
        issue(1, 1, 0, 0, 5);                 step();
        issue(1, 0, 5, 0, 10);                step(); step();
        long_drive(1, 5, 32'hDEADBEEF);       step();
        long_drive(0, 0, 0);                  step();
        step();
        check("x5_after_pop", rf_obs[5], 32'hDEADBEEF);
        issue(0, 0, 0, 0, 0);

        // Starvation: ALU owns the port while x7 waits.
        alu_rand(1); long_drive(1, 7, 32'h1234); step();
        long_drive(0, 0, 0);
        repeat (10) begin alu_rand(1); step(); end
        alu_wr_en_i = 0;                      step();
        step();
        check("x7_after_starve", rf_obs[7], 32'h1234);

        // Fill the FIFO under ALU traffic, hold a third result until space frees.
        alu_rand(1); long_drive(1, 11, 32'hA0A0_0011); step();
        alu_rand(1); long_drive(1, 12, 32'hA0A0_0012); step();
        long_drive(1, 13, 32'hA0A0_0013);
        repeat (3) begin alu_rand(1); step(); end
        alu_wr_en_i = 0;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin step(); done = m_pushed; end
        check("third_push_accepted", {31'b0, done}, 32'd1);
        long_drive(0, 0, 0);
        repeat (4) step();
        check("x11", rf_obs[11], 32'hA0A0_0011);
        check("x12", rf_obs[12], 32'hA0A0_0012);
        check("x13", rf_obs[13], 32'hA0A0_0013);

        // Outstanding cap: four reservations, fifth long issue waits for one return.
        for (int r = 1; r <= 4; r++) begin issue(1, 1, 0, 0, 5'(r)); step(); end
        issue(1, 1, 0, 0, 6);                 step();
        long_drive(1, 2, 32'h2222);           step();
        long_drive(0, 0, 0);                  step();
        step();
        issue(0, 0, 0, 0, 0);
        foreach (pend_q[i]) if (pend_q[i] != 2) begin long_drive(1, pend_q[i], 32'h100 + 32'(pend_q[i])); step(); end
        long_drive(0, 0, 0);
        repeat (3) step();
        pend_q.delete();

        // Result to x0 is drained without a register file write.
        long_drive(1, 0, 32'hFFFFFFFF);       step();
        long_drive(0, 0, 0);                  step();
        step();

        // Reset mid-traffic with two queued entries and x5 reserved.
        issue(1, 1, 0, 0, 5);                 step();
        issue(0, 0, 0, 0, 0);
        alu_rand(1); long_drive(1, 9, 32'h9);  step();
        alu_rand(1); long_drive(1, 10, 32'hA); step();
        long_drive(0, 0, 0);
        rst = 1'b1;
        repeat (3) begin alu_rand(1); step(); end
        rst = 1'b0;
        alu_wr_en_i = 0;
        issue(1, 0, 5, 5, 0);                 step();
        issue(0, 0, 0, 0, 0);
        pend_q.delete();

        // Random traffic, then drain.
        for (int c = 0; c < 500; c++) begin
            alu_rand($urandom_range(0, 9) < 4);
            issue($urandom_range(0, 1), $urandom_range(0, 9) < 4,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (!long_valid_i) begin
                if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) long_drive(1, pend_q.pop_front(), $urandom);
                else if ($urandom_range(0, 19) == 0)               long_drive(1, 0, $urandom);
            end
            step();
            if (m_pushed) long_drive(0, 0, 0);
        end
        idle();
        for (int c = 0; c < 80; c++) begin
            if (!long_valid_i && pend_q.size() > 0) long_drive(1, pend_q.pop_front(), $urandom);
            step();
            if (m_pushed) long_drive(0, 0, 0);
        end
        check("model_fifo_drained", m_fifo.size(), 0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
